// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: round-robin N:1 OBI arbiter with in-order response routing through an ID FIFO
module obi_rr_arbiter #(
  parameter int NumMgr    = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int MaxOutstd = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumMgr-1:0]             mgr_req_i,
  input  logic [NumMgr*AddrWidth-1:0]   mgr_addr_i,
  input  logic [NumMgr-1:0]             mgr_we_i,
  input  logic [NumMgr*DataWidth/8-1:0] mgr_be_i,
  input  logic [NumMgr*DataWidth-1:0]   mgr_wdata_i,
  output logic [NumMgr-1:0]             mgr_gnt_o,
  output logic [NumMgr-1:0]             mgr_rvalid_o,
  output logic [DataWidth-1:0]          mgr_rdata_o,
  output logic                          sbr_req_o,
  output logic [AddrWidth-1:0]          sbr_addr_o,
  output logic                          sbr_we_o,
  output logic [DataWidth/8-1:0]        sbr_be_o,
  output logic [DataWidth-1:0]          sbr_wdata_o,
  input  logic                          sbr_gnt_i,
  input  logic                          sbr_rvalid_i,
  input  logic [DataWidth-1:0]          sbr_rdata_i,
  output logic                          rsp_err_o
);
  localparam int BeWidth = DataWidth / 8;
  localparam int IdW     = NumMgr > 1 ? $clog2(NumMgr) : 1;
  localparam int CntW    = $clog2(MaxOutstd + 1);
  localparam int PtrW    = MaxOutstd > 1 ? $clog2(MaxOutstd) : 1;
  localparam logic [NumMgr-1:0] One = {{(NumMgr-1){1'b0}}, 1'b1};
  logic [IdW-1:0]  rr_ptr_q, winner, idx;
  logic [IdW-1:0]  fifo_q [MaxOutstd];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            found, full, push, pop;
  // scan from rr_ptr upward; iterating in reverse lets the nearest requester overwrite the others
  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = NumMgr - 1; k >= 0; k--) begin
      idx = IdW'((int'(rr_ptr_q) + k) % NumMgr);
      if (mgr_req_i[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
  assign full         = count_q == CntW'(MaxOutstd);
  assign sbr_req_o    = found & ~full;
  assign sbr_addr_o   = found ? mgr_addr_i[winner*AddrWidth +: AddrWidth] : '0;
  assign sbr_we_o     = found ? mgr_we_i[winner] : 1'b0;
  assign sbr_be_o     = found ? mgr_be_i[winner*BeWidth +: BeWidth] : '0;
  assign sbr_wdata_o  = found ? mgr_wdata_i[winner*DataWidth +: DataWidth] : '0;
  assign push         = sbr_req_o & sbr_gnt_i;
  assign pop          = sbr_rvalid_i & (count_q != '0);
  assign mgr_gnt_o    = push ? One << winner : '0;
  assign mgr_rvalid_o = pop ? One << fifo_q[rd_ptr_q] : '0;
  assign mgr_rdata_o  = sbr_rdata_i;
  assign rsp_err_o    = sbr_rvalid_i & (count_q == '0);
  // ID storage needs no reset: entries are only read while count covers them
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= winner;
  end
  // round-robin pointer, FIFO pointers and outstanding count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        rr_ptr_q <= winner == IdW'(NumMgr - 1) ? '0 : winner + 1'b1;
        wr_ptr_q <= wr_ptr_q == PtrW'(MaxOutstd - 1) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q == PtrW'(MaxOutstd - 1) ? '0 : rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// tb_obi_rr_arbiter: directed and random checks of arbitration, ID-FIFO routing, full and stray-response handling
module tb_obi_rr_arbiter;
  localparam int N = 2, AW = 32, DW = 32, BW = 4, MO = 2;
  logic            clk_i = 1'b0, rst_ni = 1'b0;
  logic [N-1:0]    mgr_req_i = '0;
  logic [N*AW-1:0] mgr_addr_i;
  logic [N-1:0]    mgr_we_i;
  logic [N*BW-1:0] mgr_be_i;
  logic [N*DW-1:0] mgr_wdata_i;
  logic [N-1:0]    mgr_gnt_o, mgr_rvalid_o;
  logic [DW-1:0]   mgr_rdata_o, sbr_wdata_o, sbr_rdata_i = '0;
  logic [AW-1:0]   sbr_addr_o;
  logic [BW-1:0]   sbr_be_o;
  logic            sbr_req_o, sbr_we_o, rsp_err_o;
  logic            sbr_gnt_i = 1'b0, sbr_rvalid_i = 1'b0;
  int checks = 0, errors = 0;
  int q[$];
  int m_rr = 0;
  assign mgr_addr_i  = {32'h0000_2000, 32'h0000_1000};
  assign mgr_we_i    = 2'b10;
  assign mgr_be_i    = {4'hF, 4'h3};
  assign mgr_wdata_i = {32'hA5A5_A5A5, 32'h1111_2222};
  obi_rr_arbiter #(.NumMgr(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstd(MO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mgr_req_i(mgr_req_i), .mgr_addr_i(mgr_addr_i), .mgr_we_i(mgr_we_i),
    .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i),
    .mgr_gnt_o(mgr_gnt_o), .mgr_rvalid_o(mgr_rvalid_o), .mgr_rdata_o(mgr_rdata_o),
    .sbr_req_o(sbr_req_o), .sbr_addr_o(sbr_addr_o), .sbr_we_o(sbr_we_o),
    .sbr_be_o(sbr_be_o), .sbr_wdata_o(sbr_wdata_o),
    .sbr_gnt_i(sbr_gnt_i), .sbr_rvalid_i(sbr_rvalid_i), .sbr_rdata_i(sbr_rdata_i),
    .rsp_err_o(rsp_err_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [68:0] fld(input int w);
    return w == 0 ? {1'b0, 4'h3, 32'h1111_2222, 32'h0000_1000}
                  : {1'b1, 4'hF, 32'hA5A5_A5A5, 32'h0000_2000};
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [N-1:0] req, input logic gnt, input logic rv, input logic [DW-1:0] rd);
    int sz, w;
    logic any, sreq, err;
    logic [N-1:0] eg, ev;
    @(negedge clk_i);
    mgr_req_i = req; sbr_gnt_i = gnt; sbr_rvalid_i = rv; sbr_rdata_i = rd;
    sz  = q.size();
    any = |req;
    w   = 0;
    for (int k = N - 1; k >= 0; k--) if (req[(m_rr + k) % N]) w = (m_rr + k) % N;
    sreq = any && sz < MO;
    eg   = (sreq && gnt) ? N'(1) << w : '0;
    err  = rv && sz == 0;
    ev   = '0;
    if (rv && sz > 0) ev = N'(1) << q.pop_front();
    if (sreq && gnt) begin
      q.push_back(w);
      m_rr = (w + 1) % N;
    end
    #1;
    chk("gnt", mgr_gnt_o, eg);
    chk("sbr_req", sbr_req_o, sreq);
    chk("rvalid", mgr_rvalid_o, ev);
    chk("rsp_err", rsp_err_o, err);
    chk("rdata", mgr_rdata_o, rd);
    chk("mux", {sbr_we_o, sbr_be_o, sbr_wdata_o, sbr_addr_o}, any ? fld(w) : '0);
    @(posedge clk_i);
    #1;
    chk("count", dut.count_q, q.size());
    chk("rr_ptr", dut.rr_ptr_q, m_rr);
  endtask
  initial begin
    #12;
    chk("rst_gnt", mgr_gnt_o, 0);
    chk("rst_sbr_req", sbr_req_o, 0);
    chk("rst_rvalid", mgr_rvalid_o, 0);
    chk("rst_err", rsp_err_o, 0);
    chk("rst_count", dut.count_q, 0);
    chk("rst_rr", dut.rr_ptr_q, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(2'b01, 1'b1, 1'b0, '0);
    step(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) step(2'b11, 1'b1, q.size() > 0, $urandom);
    step(2'b00, 1'b0, 1'b1, 32'h0BAD_F00D);
    step(2'b01, 1'b1, 1'b0, '0);
    step(2'b10, 1'b1, 1'b0, '0);
    step(2'b11, 1'b1, 1'b0, '0);
    step(2'b11, 1'b1, 1'b1, 32'h1234_5678);
    step(2'b01, 1'b1, 1'b0, '0);
    step(2'b00, 1'b0, 1'b1, 32'h2222_3333);
    step(2'b00, 1'b0, 1'b1, 32'h4444_5555);
    step(2'b01, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(2'b11, 1'b0, i == 0, 32'h6666_7777);
    step(2'b11, 1'b1, 1'b0, '0);
    step(2'b00, 1'b0, 1'b1, 32'h8888_9999);
    step(2'b00, 1'b0, 1'b1, 32'hBADB_AD00);
    for (int i = 0; i < 24; i++)
      step(N'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    while (q.size() > 0) step(2'b00, 1'b0, 1'b1, $urandom);
    step(2'b01, 1'b1, 1'b0, '0);
    step(2'b10, 1'b1, 1'b0, '0);
    mgr_req_i = '0; sbr_gnt_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    chk("async_count", dut.count_q, 0);
    chk("async_rr", dut.rr_ptr_q, 0);
    q.delete();
    m_rr = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(2'b00, 1'b0, 1'b1, 32'hCAFE_0001);
    step(2'b10, 1'b1, 1'b0, '0);
    step(2'b00, 1'b0, 1'b1, 32'hCAFE_0002);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
